// File: rtl/pipe_if_id_queue.sv
// pipe_if_id_queue: IF->ID instruction FIFO with valid/ready handshake and one-cycle flush
module pipe_if_id_queue #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  logic [31:0]              if_pc_plus_4,
  input  logic [31:0]              if_inst,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc_plus_4,
  output logic [31:0]              id_inst,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;
  always_comb begin
    if_ready     = !reset && !flush && (cnt_q != (AW+1)'(DEPTH));
    id_valid     = !flush && (cnt_q != '0);
    push         = if_valid && if_ready;
    pop          = id_valid && id_ready;
    id_pc_plus_4 = id_valid ? mem_q[rp_q][63:32] : 32'h0;
    id_inst      = id_valid ? mem_q[rp_q][31:0] : NOP;
    count        = cnt_q;
    wp_d         = flush ? '0 : wp_q + AW'(push);
    rp_d         = flush ? '0 : rp_q + AW'(pop);
    cnt_d        = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) mem_q[wp_q] <= {if_pc_plus_4, if_inst};
  end
endmodule

// File: tb/tb_pipe_if_id_queue.sv
// tb_pipe_if_id_queue: directed self-checking bench for pipe_if_id_queue (DEPTH=2)
module tb_pipe_if_id_queue;
  logic        clock = 1'b0;
  logic        reset, if_valid, if_ready, id_valid, id_ready, flush;
  logic [31:0] if_pc_plus_4, if_inst, id_pc_plus_4, id_inst;
  logic [1:0]  count;
  int          checks = 0;
  int          errors = 0;
  pipe_if_id_queue #(.DEPTH(2), .NOP(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc_plus_4(if_pc_plus_4), .if_inst(if_inst), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc_plus_4(id_pc_plus_4), .id_inst(id_inst),
    .flush(flush), .count(count)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
    if_valid = v;
    if_pc_plus_4 = pc;
    if_inst = inst;
    #1;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    reset = 1'b1; flush = 1'b0; id_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("rst_if_ready_low", {31'b0, if_ready}, 32'd0);
    tick();
    chk("rst_count", {30'b0, count}, 32'd0);
    chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0);
    chk("rst_id_pc", id_pc_plus_4, 32'h0);
    reset = 1'b0; #1;
    chk("rst_if_ready_high", {31'b0, if_ready}, 32'd1);
    id_ready = 1'b1;
    drive(1'b1, 32'h0000_0004, 32'h2108_0001);
    chk("t1_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t1_id_valid", {31'b0, id_valid}, 32'd1);
    chk("t1_id_inst", id_inst, 32'h2108_0001);
    chk("t1_id_pc", id_pc_plus_4, 32'h0000_0004);
    chk("t1_count1", {30'b0, count}, 32'd1);
    tick();
    chk("t1_count0", {30'b0, count}, 32'd0);
    chk("t1_nop", id_inst, 32'h0);
    id_ready = 1'b0;
    drive(1'b1, 32'h0000_0004, 32'hA000_0000); tick();
    drive(1'b1, 32'h0000_0008, 32'hA000_0001); tick();
    drive(1'b1, 32'h0000_000C, 32'hA000_0002);
    chk("t2_full_if_ready", {31'b0, if_ready}, 32'd0);
    chk("t2_full_count", {30'b0, count}, 32'd2);
    tick();
    id_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    chk("t2_out0_pc", id_pc_plus_4, 32'h0000_0004);
    chk("t2_out0_inst", id_inst, 32'hA000_0000);
    tick();
    chk("t2_out1_pc", id_pc_plus_4, 32'h0000_0008);
    chk("t2_out1_inst", id_inst, 32'hA000_0001);
    chk("t2_count1", {30'b0, count}, 32'd1);
    tick();
    chk("t2_count0", {30'b0, count}, 32'd0);
    chk("t2_no_third", {31'b0, id_valid}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h3000 + 32'(i));
      chk("t3_if_ready", {31'b0, if_ready}, 32'd1);
      if (i > 0) begin
        chk("t3_stream_pc", id_pc_plus_4, 32'h100 + 32'(4 * (i - 1)));
        chk("t3_stream_inst", id_inst, 32'h3000 + 32'(i - 1));
        chk("t3_stream_count", {30'b0, count}, 32'd1);
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    chk("t3_last_pc", id_pc_plus_4, 32'h124);
    chk("t3_last_inst", id_inst, 32'h3009);
    tick();
    chk("t3_drained", {30'b0, count}, 32'd0);
    id_ready = 1'b0;
    drive(1'b1, 32'h200, 32'hB000_0000); tick();
    drive(1'b1, 32'h204, 32'hB000_0001); tick();
    chk("t4_pre_count", {30'b0, count}, 32'd2);
    flush = 1'b1;
    drive(1'b1, 32'h208, 32'hB000_0002);
    chk("t4_flush_if_ready", {31'b0, if_ready}, 32'd0);
    chk("t4_flush_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t4_flush_nop", id_inst, 32'h0);
    tick();
    flush = 1'b0;
    drive(1'b1, 32'h300, 32'hC000_0000);
    chk("t4_post_count", {30'b0, count}, 32'd0);
    chk("t4_post_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t4_post_if_ready", {31'b0, if_ready}, 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t4_redirect_pc", id_pc_plus_4, 32'h300);
    chk("t4_redirect_inst", id_inst, 32'hC000_0000);
    chk("t4_redirect_count", {30'b0, count}, 32'd1);
    id_ready = 1'b1; #1;
    tick();
    chk("t4_drained", {30'b0, count}, 32'd0);
    id_ready = 1'b0;
    drive(1'b1, 32'h400, 32'hD000_0000); tick();
    drive(1'b1, 32'h404, 32'hD000_0001); tick();
    id_ready = 1'b1;
    drive(1'b1, 32'h408, 32'hD000_0002);
    chk("t5_full_if_ready", {31'b0, if_ready}, 32'd0);
    chk("t5_full_head", id_pc_plus_4, 32'h400);
    chk("t5_full_count", {30'b0, count}, 32'd2);
    tick();
    id_ready = 1'b0; #1;
    chk("t5_count1", {30'b0, count}, 32'd1);
    chk("t5_if_ready_back", {31'b0, if_ready}, 32'd1);
    chk("t5_head1", id_pc_plus_4, 32'h404);
    tick();
    id_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    chk("t5_count2", {30'b0, count}, 32'd2);
    chk("t5_out_404", id_pc_plus_4, 32'h404);
    tick();
    chk("t5_out_408", id_pc_plus_4, 32'h408);
    chk("t5_out_408_inst", id_inst, 32'hD000_0002);
    tick();
    chk("t5_drained", {30'b0, count}, 32'd0);
    id_ready = 1'b0;
    drive(1'b1, 32'h500, 32'hE000_0000); tick();
    drive(1'b1, 32'h504, 32'hE000_0001); tick();
    drive(1'b0, 32'h0, 32'h0);
    chk("t6_pre_count", {30'b0, count}, 32'd2);
    reset = 1'b1; #1;
    chk("t6_rst_if_ready", {31'b0, if_ready}, 32'd0);
    tick();
    reset = 1'b0; #1;
    chk("t6_count", {30'b0, count}, 32'd0);
    chk("t6_id_valid", {31'b0, id_valid}, 32'd0);
    chk("t6_if_ready", {31'b0, if_ready}, 32'd1);
    chk("t6_nop", id_inst, 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_if_id_queue.md
# pipe_if_id_queue

Instruction queue between the instruction-fetch stage and the decode stage of the 5-stage pipelined MIPS CPU. It captures each fetched {pc_plus_4, inst} pair from IF, buffers up to DEPTH entries, and presents the oldest to ID with a valid/ready handshake. Fetch can run ahead while ID is stalled by a load-use hazard. A branch/jump redirect flushes all buffered wrong-path instructions in one cycle.

## Interface
Parameters:
- DEPTH, 2, number of entries; power of two, >= 2
- NOP, 32'h0000_0000, instruction word driven on id_inst when id_valid is low (MIPS sll $0,$0,0)

Ports:
- clock  in  1  rising-edge clock; the only clock in the block
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock
- if_valid  in  1  IF presents a fetched instruction this cycle
- if_ready  out  1  queue accepts the IF entry this cycle
- if_pc_plus_4  in  32  PC+4 of the fetched instruction, from the IF adder
- if_inst  in  32  fetched instruction word
- id_valid  out  1  head entry is valid for ID
- id_ready  in  1  ID consumes the head entry this cycle; low = ID stall
- id_pc_plus_4  out  32  PC+4 of the head entry
- id_inst  out  32  instruction word of the head entry; NOP when id_valid = 0
- flush  in  1  redirect from ID/EX (taken branch, jump, jr); discards all entries
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- Storage: circular buffer of DEPTH x 64 bits. Write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH. Occupancy register cnt.
- push = if_valid & if_ready; pop = id_valid & id_ready.
- if_ready = !reset & !flush & (cnt != DEPTH). It does not depend on id_ready, so a full queue refuses a push even when ID pops in the same cycle.
- id_valid = !flush & (cnt != 0). id_pc_plus_4 and id_inst come from entry rp. No combinational path runs from the if_* inputs to the id_* outputs.
- id_inst = NOP and id_pc_plus_4 = 32'h0 whenever id_valid = 0.
- Update at the clock edge, in priority order:
  1. reset: wp = rp = cnt = 0.
  2. flush: wp = rp = cnt = 0. A concurrent push or pop is discarded; storage contents are don't-care.
  3. Otherwise, push writes entry wp and increments wp. Pop increments rp. cnt += push - pop, so push and pop together leave cnt unchanged.
- Ordering is strictly FIFO. An entry is never duplicated or dropped except by flush or reset.
- count = cnt.

## Timing
- Reset values (state after the reset edge): cnt = 0, count = 0, id_valid = 0, id_inst = NOP, id_pc_plus_4 = 0, if_ready = 1 once reset deasserts. if_ready = 0 while reset is high.
- Reset mid-operation discards all entries, exactly like flush.
- Latency: an entry pushed at edge N is visible on id_* in cycle N+1, and can be popped at edge N+1 at the earliest.
- Sustained throughput: 1 entry/cycle when if_valid and id_ready are held high.
- Empty: id_valid = 0, so no pop occurs. A push in that cycle makes cnt = 1.
- Full (cnt = DEPTH): if_ready = 0. A pop in the same cycle gives cnt = DEPTH-1, and if_ready returns to 1 next cycle.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no gap or bubble.
- Flush cycle: if_ready = 0 and id_valid = 0 combinationally. Next cycle the queue is empty, and the IF entry from the redirected PC can be pushed then.
- Flush and reset asserted together behave as reset.

## Test plan
- Reset, then push 32'h2108_0001 with pc_plus_4 32'h0000_0004 and id_ready = 1. Required: id_valid = 1 with those values one cycle later, popped that cycle, then count = 0 and id_inst = NOP.
- Hold id_ready = 0 and push 3 entries (DEPTH = 2). Required: first two accepted, if_ready = 0 and count = 2 on the third cycle. Raise id_ready: outputs 32'h...04, then 32'h...08, in order.
- Stream 10 back-to-back entries with id_ready = 1. Required: one pop per cycle after the first-cycle latency, pointers wrap, count stays at 1.
- With count = 2 and a push offered, assert flush for one cycle. Required: if_ready = 0 and id_valid = 0 that cycle, count = 0 next cycle, and no old entry ever appears on id_*.
- Full queue with id_ready = 1 and if_valid = 1. Required: pop occurs, push refused, count goes 2 -> 1, then the push is accepted on the following cycle.
- Assert reset with count = 2. Required: count = 0 and id_valid = 0 after the edge, and if_ready = 1 after reset deasserts.
